// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp
//   Duty-cycle slew stage feeding the multi-channel PWM generator. Per-channel
//   target duties are written over a valid/ready handshake; once per PWM
//   period (period_tick) a single shared sweep engine visits every channel in
//   order and moves its applied duty toward its target by at most STEP counts,
//   giving soft-start / soft-stop on every output.
//
//   Optional feature macro: PWM_RAMP_BYPASS_EN
//     When defined, adds input `bypass`. Accepted writes made while bypass = 1
//     load both target and applied duty, so DC_bus steps immediately.
//
// Ports
//   clk          system clock
//   reset        asynchronous reset, active-high
//   period_tick  one-cycle pulse at the start of each PWM period
//   wr_valid     target write request
//   wr_ready     target write accept (high while idle)
//   wr_ch        channel index of the write; indices >= NPWM are discarded
//   wr_duty      new target duty
//   bypass       (PWM_RAMP_BYPASS_EN only) load applied duty directly
//   DC_bus       applied duties, channel i at [i*Resolution +: Resolution]
//   busy         sweep in progress
//   at_target    bit i high when applied[i] == target[i]
//   overrun      sticky flag: period_tick arrived during a sweep
module pwm_duty_ramp #(
  parameter int NPWM       = 5,
  parameter int Resolution = 8,
  parameter int STEP       = 1,
  parameter int CHW        = (NPWM > 1) ? $clog2(NPWM) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       period_tick,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [CHW-1:0]             wr_ch,
  input  logic [Resolution-1:0]      wr_duty,
`ifdef PWM_RAMP_BYPASS_EN
  input  logic                       bypass,
`endif
  output logic [NPWM*Resolution-1:0] DC_bus,
  output logic                       busy,
  output logic [NPWM-1:0]            at_target,
  output logic                       overrun
);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  localparam logic [CHW-1:0]     LAST_CH = CHW'(NPWM - 1);
  localparam logic [Resolution:0] STEP_W = (Resolution + 1)'(STEP);

  state_t                state, state_nxt;
  logic [CHW-1:0]        idx, idx_nxt;
  logic [Resolution-1:0] target  [NPWM];
  logic [Resolution-1:0] applied [NPWM];
  logic                  wr_fire;

  logic [Resolution:0]   sel_a, sel_t;
  logic [Resolution:0]   a_up, dn_floor;
  logic [Resolution-1:0] slew_duty;

  // Both flags come straight off the state register.
  assign busy     = (state == SWEEP);
  assign wr_ready = (state == IDLE);
  assign wr_fire  = wr_valid & wr_ready;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (period_tick) begin
          state_nxt = SWEEP;
          idx_nxt   = '0;
        end
      end
      SWEEP: begin
        if (idx == LAST_CH) begin
          state_nxt = IDLE;
        end else begin
          idx_nxt = idx + CHW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shared slew datapath for the channel currently addressed by idx.
  // Arithmetic is one bit wider than the duty so neither direction wraps.
  always_comb begin
    sel_a = '0;
    sel_t = '0;
    for (int unsigned i = 0; i < NPWM; i++) begin
      if (idx == CHW'(i)) begin
        sel_a = {1'b0, applied[i]};
        sel_t = {1'b0, target[i]};
      end
    end
    a_up     = sel_a + STEP_W;
    dn_floor = sel_t + STEP_W;
    if (sel_a < sel_t) begin
      slew_duty = (a_up > sel_t) ? sel_t[Resolution-1:0] : a_up[Resolution-1:0];
    end else if (sel_a > sel_t) begin
      // sel_a < target + STEP means a full step would pass the target
      slew_duty = (sel_a < dn_floor) ? sel_t[Resolution-1:0]
                                     : Resolution'(sel_a - STEP_W);
    end else begin
      slew_duty = sel_a[Resolution-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if ((state == SWEEP) && period_tick) begin
        overrun <= 1'b1;
      end
    end
  end

  // Writes land only in IDLE and the sweep touches applied only in SWEEP,
  // so the write/bypass path and the slew path never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NPWM; i++) begin
        target[i]  <= '0;
        applied[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NPWM; i++) begin
        if (wr_fire && (wr_ch == CHW'(i))) begin
          target[i] <= wr_duty;
`ifdef PWM_RAMP_BYPASS_EN
          if (bypass) begin
            applied[i] <= wr_duty;
          end
`endif
        end
        if ((state == SWEEP) && (idx == CHW'(i))) begin
          applied[i] <= slew_duty;
        end
      end
    end
  end

  always_comb begin
    DC_bus    = '0;
    at_target = '0;
    for (int unsigned i = 0; i < NPWM; i++) begin
      DC_bus[i*Resolution +: Resolution] = applied[i];
      at_target[i]                       = (applied[i] == target[i]);
    end
  end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
module tb_pwm_duty_ramp;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  // STEP = 1 instance
  logic        tick = 1'b0, valid = 1'b0;
  logic [2:0]  ch = '0;
  logic [7:0]  duty = '0;
  logic        ready, busy, ovr;
  logic [39:0] bus;
  logic [4:0]  at;

  // STEP = 3 instance
  logic        t3_tick = 1'b0, t3_valid = 1'b0;
  logic [2:0]  t3_ch = '0;
  logic [7:0]  t3_duty = '0;
  logic        t3_ready, t3_busy, t3_ovr;
  logic [39:0] t3_bus;
  logic [4:0]  t3_at;

`ifdef PWM_RAMP_BYPASS_EN
  logic        bypass = 1'b0;
  logic        t3_bypass = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pwm_duty_ramp #(.NPWM(5), .Resolution(8), .STEP(1)) dut (
    .clk(clk), .reset(reset), .period_tick(tick), .wr_valid(valid),
    .wr_ready(ready), .wr_ch(ch), .wr_duty(duty),
`ifdef PWM_RAMP_BYPASS_EN
    .bypass(bypass),
`endif
    .DC_bus(bus), .busy(busy), .at_target(at), .overrun(ovr)
  );

  pwm_duty_ramp #(.NPWM(5), .Resolution(8), .STEP(3)) dut3 (
    .clk(clk), .reset(reset), .period_tick(t3_tick), .wr_valid(t3_valid),
    .wr_ready(t3_ready), .wr_ch(t3_ch), .wr_duty(t3_duty),
`ifdef PWM_RAMP_BYPASS_EN
    .bypass(t3_bypass),
`endif
    .DC_bus(t3_bus), .busy(t3_busy), .at_target(t3_at), .overrun(t3_ovr)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick1;
    tick = 1'b1; cyc(1); tick = 1'b0; cyc(6);
  endtask

  task automatic tick3;
    t3_tick = 1'b1; cyc(1); t3_tick = 1'b0; cyc(6);
  endtask

  task automatic write3(input logic [7:0] d);
    t3_valid = 1'b1; t3_ch = 3'd0; t3_duty = d; cyc(1); t3_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cyc(2);
    n_cmp++; if (bus !== 40'h0) begin n_err++; $display("FAIL reset_bus got %h expected 0", bus); end
    n_cmp++; if (at !== 5'b11111) begin n_err++; $display("FAIL reset_at got %b expected 11111", at); end
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b expected 1", ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b expected 0", busy); end
    n_cmp++; if (ovr !== 1'b0) begin n_err++; $display("FAIL reset_overrun got %b expected 0", ovr); end
    n_cmp++; if (t3_bus !== 40'h0) begin n_err++; $display("FAIL reset_bus3 got %h expected 0", t3_bus); end
    reset = 1'b0;
    cyc(2);
  endtask

  task automatic test_ramp_up;
    int exp_v;
    valid = 1'b1; ch = 3'd2; duty = 8'd4; cyc(1); valid = 1'b0;
    n_cmp++; if (at[2] !== 1'b0) begin n_err++; $display("FAIL ramp_at_init got %b expected 0", at[2]); end
    for (int k = 0; k < 5; k++) begin
      exp_v = (k + 1 < 4) ? k + 1 : 4;
      tick = 1'b1; cyc(1); tick = 1'b0;
      if (k == 0) begin
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ramp_busy got %b expected 1", busy); end
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL ramp_ready got %b expected 0", ready); end
      end
      cyc(2);
      n_cmp++; if (bus[23:16] !== 8'(k)) begin n_err++; $display("FAIL ramp_before[%0d] got %0d expected %0d", k, bus[23:16], k); end
      cyc(1);
      n_cmp++; if (bus[23:16] !== 8'(exp_v)) begin n_err++; $display("FAIL ramp_after[%0d] got %0d expected %0d", k, bus[23:16], exp_v); end
      cyc(2);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ramp_done[%0d] got busy %b expected 0", k, busy); end
      n_cmp++; if (at[2] !== (k >= 3)) begin n_err++; $display("FAIL ramp_at[%0d] got %b expected %b", k, at[2], (k >= 3)); end
      cyc(14);
    end
  endtask

  task automatic test_clamp;
    write3(8'd250);
    repeat (83) tick3;
    n_cmp++; if (t3_bus[7:0] !== 8'd249) begin n_err++; $display("FAIL clamp_249 got %0d expected 249", t3_bus[7:0]); end
    tick3;
    n_cmp++; if (t3_bus[7:0] !== 8'd250) begin n_err++; $display("FAIL clamp_250 got %0d expected 250", t3_bus[7:0]); end
    n_cmp++; if (t3_at[0] !== 1'b1) begin n_err++; $display("FAIL clamp_at250 got %b expected 1", t3_at[0]); end
    write3(8'd255);
    tick3;
    n_cmp++; if (t3_bus[7:0] !== 8'd253) begin n_err++; $display("FAIL clamp_253 got %0d expected 253", t3_bus[7:0]); end
    tick3;
    n_cmp++; if (t3_bus[7:0] !== 8'd255) begin n_err++; $display("FAIL clamp_255 got %0d expected 255", t3_bus[7:0]); end
    tick3;
    n_cmp++; if (t3_bus[7:0] !== 8'd255) begin n_err++; $display("FAIL clamp_hold got %0d expected 255", t3_bus[7:0]); end
    n_cmp++; if (t3_at[0] !== 1'b1) begin n_err++; $display("FAIL clamp_at255 got %b expected 1", t3_at[0]); end
    write3(8'd2);
    repeat (84) tick3;
    n_cmp++; if (t3_bus[7:0] !== 8'd3) begin n_err++; $display("FAIL down_3 got %0d expected 3", t3_bus[7:0]); end
    tick3;
    n_cmp++; if (t3_bus[7:0] !== 8'd2) begin n_err++; $display("FAIL down_2 got %0d expected 2", t3_bus[7:0]); end
    write3(8'd0);
    tick3;
    n_cmp++; if (t3_bus[7:0] !== 8'd0) begin n_err++; $display("FAIL down_0 got %0d expected 0", t3_bus[7:0]); end
    n_cmp++; if (t3_at[0] !== 1'b1) begin n_err++; $display("FAIL down_at0 got %b expected 1", t3_at[0]); end
  endtask

  task automatic test_handshake;
    int wcnt;
    // write on the tick edge: sweep sees the new target
    tick = 1'b1; valid = 1'b1; ch = 3'd1; duty = 8'd9; cyc(1);
    tick = 1'b0; valid = 1'b0;
    cyc(2);
    n_cmp++; if (bus[15:8] !== 8'd1) begin n_err++; $display("FAIL collide_ch1 got %0d expected 1", bus[15:8]); end
    cyc(7);
    // write held across a sweep
    tick = 1'b1; cyc(1); tick = 1'b0;
    valid = 1'b1; ch = 3'd0; duty = 8'd6;
    wcnt = 0;
    while (ready !== 1'b1 && wcnt < 20) begin wcnt++; cyc(1); end
    n_cmp++; if (wcnt !== 5) begin n_err++; $display("FAIL held_wait got %0d cycles expected 5", wcnt); end
    cyc(1); valid = 1'b0;
    n_cmp++; if (at[0] !== 1'b0) begin n_err++; $display("FAIL held_at0 got %b expected 0", at[0]); end
    cyc(4);
    tick1;
    n_cmp++; if (bus !== 40'h0000040301) begin n_err++; $display("FAIL held_bus got %h expected 0000040301", bus); end
    // out-of-range channel: accepted, discarded
    valid = 1'b1; ch = 3'd7; duty = 8'd55; cyc(1); valid = 1'b0;
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL ch7_ready got %b expected 1", ready); end
    n_cmp++; if (bus !== 40'h0000040301) begin n_err++; $display("FAIL ch7_bus got %h expected 0000040301", bus); end
    n_cmp++; if (at !== 5'b11100) begin n_err++; $display("FAIL ch7_at got %b expected 11100", at); end
    tick1;
    n_cmp++; if (bus !== 40'h0000040402) begin n_err++; $display("FAIL ch7_sweep got %h expected 0000040402", bus); end
    n_cmp++; if (at !== 5'b11100) begin n_err++; $display("FAIL ch7_at2 got %b expected 11100", at); end
  endtask

  task automatic test_overrun;
    int bc;
    n_cmp++; if (ovr !== 1'b0) begin n_err++; $display("FAIL ovr_pre got %b expected 0", ovr); end
    bc = 0;
    tick = 1'b1; cyc(1); tick = 1'b0;
    if (busy === 1'b1) bc++;
    cyc(1);
    if (busy === 1'b1) bc++;
    tick = 1'b1; cyc(1); tick = 1'b0;
    n_cmp++; if (ovr !== 1'b1) begin n_err++; $display("FAIL ovr_set got %b expected 1", ovr); end
    while (busy === 1'b1 && bc < 20) begin bc++; cyc(1); end
    n_cmp++; if (bc !== 5) begin n_err++; $display("FAIL ovr_sweep_len got %0d expected 5", bc); end
    cyc(10);
    n_cmp++; if (ovr !== 1'b1) begin n_err++; $display("FAIL ovr_sticky got %b expected 1", ovr); end
    n_cmp++; if (bus !== 40'h0000040503) begin n_err++; $display("FAIL ovr_bus got %h expected 0000040503", bus); end
  endtask

`ifdef PWM_RAMP_BYPASS_EN
  task automatic test_bypass;
    bypass = 1'b1; valid = 1'b1; ch = 3'd3; duty = 8'd200; cyc(1);
    valid = 1'b0; bypass = 1'b0;
    n_cmp++; if (bus[31:24] !== 8'd200) begin n_err++; $display("FAIL bypass_bus got %0d expected 200", bus[31:24]); end
    n_cmp++; if (at[3] !== 1'b1) begin n_err++; $display("FAIL bypass_at got %b expected 1", at[3]); end
    cyc(2);
  endtask
`endif

  task automatic test_reset_mid_sweep;
    tick = 1'b1; cyc(1); tick = 1'b0;
    cyc(2);
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (bus !== 40'h0) begin n_err++; $display("FAIL mid_bus got %h expected 0", bus); end
    n_cmp++; if (at !== 5'b11111) begin n_err++; $display("FAIL mid_at got %b expected 11111", at); end
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL mid_ready got %b expected 1", ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy got %b expected 0", busy); end
    n_cmp++; if (ovr !== 1'b0) begin n_err++; $display("FAIL mid_overrun got %b expected 0", ovr); end
    cyc(1);
    reset = 1'b0;
    cyc(1);
    tick1;
    n_cmp++; if (bus !== 40'h0) begin n_err++; $display("FAIL post_bus got %h expected 0", bus); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_busy got %b expected 0", busy); end
  endtask

  initial begin
    test_reset;
    test_ramp_up;
    test_clamp;
    test_handshake;
    test_overrun;
`ifdef PWM_RAMP_BYPASS_EN
    test_bypass;
`endif
    test_reset_mid_sweep;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
